// File: rtl/alu_status_unit_pkg.sv
// Shared constants for the ALU status stage: branch condition codes,
// trap FSM state encoding and status-flag bit positions.
package alu_status_unit_pkg;

  localparam logic [2:0] BR_NEVER = 3'b000;
  localparam logic [2:0] BR_Z     = 3'b001;
  localparam logic [2:0] BR_NZ    = 3'b010;
  localparam logic [2:0] BR_N     = 3'b011;
  localparam logic [2:0] BR_V     = 3'b100;
  localparam logic [2:0] BR_LE    = 3'b101;
  localparam logic [2:0] BR_GT    = 3'b110;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef logic [2:0] flags_t;

endpackage

// File: rtl/alu_status_unit_if.sv
// Bus between the ALU/control unit and the status stage; the datapath side
// drives through the master modport, the status stage uses the slave modport.
interface alu_status_unit_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  import alu_status_unit_pkg::*;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zout;
  logic              alu_vout;
  logic              alu_nout;
  logic              flag_we;
  logic              ovf_chk;
  logic [PC_W-1:0]   pc_in;
  logic [2:0]        br_cond;
  logic              trap_ack;
  flags_t            flags_q;
  logic              branch_taken;
  logic              trap_req;
  logic [PC_W-1:0]   trap_epc;
  logic [DATA_W-1:0] trap_val;
  logic              ovf_lost;
  logic [CNT_W-1:0]  ovf_count;

  modport master (
    output alu_result, alu_zout, alu_vout, alu_nout, flag_we, ovf_chk,
           pc_in, br_cond, trap_ack,
    input  flags_q, branch_taken, trap_req, trap_epc, trap_val, ovf_lost,
           ovf_count
  );

  modport slave (
    input  alu_result, alu_zout, alu_vout, alu_nout, flag_we, ovf_chk,
           pc_in, br_cond, trap_ack,
    output flags_q, branch_taken, trap_req, trap_epc, trap_val, ovf_lost,
           ovf_count
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decoder: selects one predicate of the
// architectural {n,v,z} flags according to br_cond.
module branch_cond_eval
  import alu_status_unit_pkg::*;
(
  input  logic [2:0] i_br_cond,
  input  flags_t     i_flags,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_br_cond)
      BR_NEVER: o_taken = 1'b0;
      BR_Z:     o_taken = i_flags[FLAG_Z];
      BR_NZ:    o_taken = ~i_flags[FLAG_Z];
      BR_N:     o_taken = i_flags[FLAG_N];
      BR_V:     o_taken = i_flags[FLAG_V];
      BR_LE:    o_taken = i_flags[FLAG_N] | i_flags[FLAG_Z];
      BR_GT:    o_taken = ~i_flags[FLAG_N] & ~i_flags[FLAG_Z];
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_unit.sv
// ALU status register, flag-based branch evaluation and held overflow trap.
// Define ALU_STATUS_OVF_CNT_EN to build the saturating overflow event counter.
module alu_status_unit
  import alu_status_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_status_unit_if.slave  bus
);

  flags_t            r_flags;
  logic [0:0]        r_state;
  logic [PC_W-1:0]   r_trap_epc;
  logic [DATA_W-1:0] r_trap_val;
  logic              r_ovf_lost;
  logic              w_event;
  logic              w_taken;

  assign w_event = bus.ovf_chk & bus.alu_vout;

  branch_cond_eval u_branch_cond_eval (
    .i_br_cond (bus.br_cond),
    .i_flags   (r_flags),
    .o_taken   (w_taken)
  );

  // A trap is pending exactly while in PEND; an ack coinciding with a new
  // event retires the old trap and captures the new one without dropping req.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags    <= '0;
      r_state    <= ST_IDLE;
      r_trap_epc <= '0;
      r_trap_val <= '0;
      r_ovf_lost <= 1'b0;
    end else begin
      if (bus.flag_we) begin
        r_flags <= {bus.alu_nout, bus.alu_vout, bus.alu_zout};
      end
      case (r_state)
        ST_IDLE: begin
          if (w_event) begin
            r_trap_epc <= bus.pc_in;
            r_trap_val <= bus.alu_result;
            r_state    <= ST_PEND;
          end
        end
        default: begin
          if (bus.trap_ack) begin
            if (w_event) begin
              r_trap_epc <= bus.pc_in;
              r_trap_val <= bus.alu_result;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_event) begin
            r_ovf_lost <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef ALU_STATUS_OVF_CNT_EN
  logic [CNT_W-1:0] r_ovf_count;

  // Counts every trap event, including lost ones, and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_event && (r_ovf_count != {CNT_W{1'b1}})) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign bus.ovf_count = r_ovf_count;
`else
  assign bus.ovf_count = {CNT_W{1'b0}};
`endif

  assign bus.flags_q      = r_flags;
  assign bus.branch_taken = w_taken;
  assign bus.trap_req     = (r_state == ST_PEND);
  assign bus.trap_epc     = r_trap_epc;
  assign bus.trap_val     = r_trap_val;
  assign bus.ovf_lost     = r_ovf_lost;

endmodule
